// File: rtl/jtag_dma_engine.sv
// System-clock DMA engine behind JTAG chain1: moves word blocks between the
// ping-pong buffer and the system bus in bursts of at most MAX_BURST words.
module jtag_dma_engine #(
  parameter int unsigned BUF_AW    = 9,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic              system_clk,
  input  logic              system_reset,
  input  logic              dma_launch_read,
  input  logic              dma_launch_write,
  input  logic [31:0]       dma_address,
  input  logic [3:0]        dma_byte_enable,
  input  logic [7:0]        dma_burst_size,
  input  logic [7:0]        dma_block_size,
  output logic              dma_busy,
  output logic              dma_done,
  output logic              dma_error,
  output logic              switch_ready,
  output logic [BUF_AW-1:0] pp_address,
  output logic              pp_write_enable,
  output logic [31:0]       pp_data_in,
  input  logic [31:0]       pp_data_out,
  output logic              bus_request,
  input  logic              bus_grant,
  output logic              bus_begin_transaction,
  output logic [31:0]       bus_address_data_out,
  output logic [3:0]        bus_byte_enables,
  output logic [7:0]        bus_burst_size,
  output logic              bus_read_n_write,
  output logic              bus_data_valid_out,
  output logic              bus_end_transaction_out,
  input  logic              bus_busy_in,
  input  logic              bus_data_valid_in,
  input  logic [31:0]       bus_address_data_in,
  input  logic              bus_end_transaction_in,
  input  logic              bus_error_in
);

  localparam int unsigned CW = $clog2(MAX_BURST + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_REQ, S_BEGIN, S_WDATA, S_RDATA, S_WEND, S_NEXT, S_ERR, S_DONE
  } state_t;

  state_t            state_q;
  logic [31:0]       addr_q;
  logic [3:0]        be_q;
  logic [7:0]        bsz_q;
  logic [7:0]        remaining_q;
  logic              is_read_q;
  logic [BUF_AW-1:0] pp_base_q;
  logic [BUF_AW-1:0] pp_address_q;
  logic [CW-1:0]     cnt_q;
  logic [CW-1:0]     len_q;
  logic [CW-1:0]     len_d;
  logic [8:0]        want_len;
  logic [31:0]       skid_q;
  logic              skid_vld_q;
  logic              bus_active;

  logic        dma_busy_q, dma_done_q, dma_error_q, switch_ready_q;
  logic        pp_we_q;
  logic [31:0] pp_data_in_q;
  logic        bus_request_q, bus_begin_q, bus_rnw_q, bus_dv_q, bus_end_q;
  logic [31:0] bus_ad_q;
  logic [3:0]  bus_be_q;
  logic [7:0]  bus_burst_q;

  // Words in the next burst: min(preferred, MAX_BURST, remaining)
  always_comb begin
    want_len = 9'(bsz_q) + 9'd1;
    if (want_len > 9'(MAX_BURST))   want_len = 9'(MAX_BURST);
    if (want_len > 9'(remaining_q)) want_len = 9'(remaining_q);
    len_d = CW'(want_len);
  end

  assign bus_active = state_q inside {S_REQ, S_BEGIN, S_WDATA, S_RDATA, S_WEND};

  // Write beats keep the buffer address two words ahead of the beat on the bus;
  // a stall parks the in-flight word in skid_q so no beat is lost.
  always_ff @(posedge system_clk) begin
    if (system_reset) begin
      state_q        <= S_IDLE;
      addr_q         <= '0;
      be_q           <= '0;
      bsz_q          <= '0;
      remaining_q    <= '0;
      is_read_q      <= 1'b0;
      pp_base_q      <= '0;
      pp_address_q   <= '0;
      cnt_q          <= '0;
      len_q          <= '0;
      skid_q         <= '0;
      skid_vld_q     <= 1'b0;
      dma_busy_q     <= 1'b0;
      dma_done_q     <= 1'b0;
      dma_error_q    <= 1'b0;
      switch_ready_q <= 1'b1;
      pp_we_q        <= 1'b0;
      pp_data_in_q   <= '0;
      bus_request_q  <= 1'b0;
      bus_begin_q    <= 1'b0;
      bus_ad_q       <= '0;
      bus_be_q       <= '0;
      bus_burst_q    <= '0;
      bus_rnw_q      <= 1'b0;
      bus_dv_q       <= 1'b0;
      bus_end_q      <= 1'b0;
    end else begin
      dma_done_q  <= 1'b0;
      pp_we_q     <= 1'b0;
      bus_begin_q <= 1'b0;
      bus_end_q   <= 1'b0;
      if (bus_error_in && bus_active) begin
        state_q       <= S_ERR;
        dma_error_q   <= 1'b1;
        bus_request_q <= 1'b0;
        bus_ad_q      <= '0;
        bus_be_q      <= '0;
        bus_burst_q   <= '0;
        bus_rnw_q     <= 1'b0;
        bus_dv_q      <= 1'b0;
        skid_vld_q    <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (dma_launch_read || dma_launch_write) begin
              is_read_q      <= dma_launch_read;
              addr_q         <= dma_address;
              be_q           <= dma_byte_enable;
              bsz_q          <= dma_burst_size;
              remaining_q    <= dma_block_size;
              pp_base_q      <= '0;
              pp_address_q   <= '0;
              dma_error_q    <= 1'b0;
              switch_ready_q <= 1'b0;
              if (dma_block_size == 8'd0) begin
                dma_done_q <= 1'b1;
                state_q    <= S_DONE;
              end else begin
                dma_busy_q    <= 1'b1;
                bus_request_q <= 1'b1;
                state_q       <= S_REQ;
              end
            end
          end
          S_REQ: begin
            if (bus_grant) begin
              bus_request_q <= 1'b0;
              bus_begin_q   <= 1'b1;
              bus_ad_q      <= {addr_q[31:2], 2'b00};
              bus_be_q      <= be_q;
              bus_burst_q   <= 8'(len_d) - 8'd1;
              bus_rnw_q     <= is_read_q;
              len_q         <= len_d;
              cnt_q         <= '0;
              skid_vld_q    <= 1'b0;
              pp_address_q  <= pp_address_q + BUF_AW'(1);
              state_q       <= S_BEGIN;
            end
          end
          S_BEGIN: begin
            if (is_read_q) begin
              bus_ad_q <= '0;
              bus_be_q <= '0;
              state_q  <= S_RDATA;
            end else begin
              bus_ad_q     <= pp_data_out;
              bus_dv_q     <= 1'b1;
              pp_address_q <= pp_address_q + BUF_AW'(1);
              state_q      <= S_WDATA;
            end
          end
          S_WDATA: begin
            if (!bus_busy_in) begin
              cnt_q <= cnt_q + CW'(1);
              if (cnt_q + CW'(1) == len_q) begin
                bus_dv_q  <= 1'b0;
                bus_ad_q  <= '0;
                bus_be_q  <= '0;
                bus_end_q <= 1'b1;
                state_q   <= S_WEND;
              end else begin
                bus_ad_q     <= skid_vld_q ? skid_q : pp_data_out;
                skid_vld_q   <= 1'b0;
                pp_address_q <= pp_address_q + BUF_AW'(1);
              end
            end else if (!skid_vld_q) begin
              skid_q     <= pp_data_out;
              skid_vld_q <= 1'b1;
            end
          end
          S_RDATA: begin
            if (bus_data_valid_in && (cnt_q != len_q)) begin
              pp_we_q      <= 1'b1;
              pp_data_in_q <= bus_address_data_in;
              pp_address_q <= pp_base_q + BUF_AW'(cnt_q);
              cnt_q        <= cnt_q + CW'(1);
            end
            if (bus_end_transaction_in) state_q <= S_WEND;
          end
          S_WEND: begin
            bus_rnw_q   <= 1'b0;
            bus_burst_q <= '0;
            state_q     <= S_NEXT;
          end
          // Early-ended bursts resume from the first word not yet moved
          S_NEXT: begin
            remaining_q  <= remaining_q - 8'(cnt_q);
            addr_q       <= addr_q + (32'(cnt_q) << 2);
            pp_base_q    <= pp_base_q + BUF_AW'(cnt_q);
            pp_address_q <= pp_base_q + BUF_AW'(cnt_q);
            if (remaining_q == 8'(cnt_q)) begin
              dma_done_q <= 1'b1;
              dma_busy_q <= 1'b0;
              state_q    <= S_DONE;
            end else begin
              bus_request_q <= 1'b1;
              state_q       <= S_REQ;
            end
          end
          S_ERR: begin
            dma_done_q <= 1'b1;
            dma_busy_q <= 1'b0;
            state_q    <= S_DONE;
          end
          S_DONE: begin
            switch_ready_q <= 1'b1;
            state_q        <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign dma_busy                = dma_busy_q;
  assign dma_done                = dma_done_q;
  assign dma_error               = dma_error_q;
  assign switch_ready            = switch_ready_q;
  assign pp_address              = pp_address_q;
  assign pp_write_enable         = pp_we_q;
  assign pp_data_in              = pp_data_in_q;
  assign bus_request             = bus_request_q;
  assign bus_begin_transaction   = bus_begin_q;
  assign bus_address_data_out    = bus_ad_q;
  assign bus_byte_enables        = bus_be_q;
  assign bus_burst_size          = bus_burst_q;
  assign bus_read_n_write        = bus_rnw_q;
  assign bus_data_valid_out      = bus_dv_q;
  assign bus_end_transaction_out = bus_end_q;

endmodule

// File: tb/tb_jtag_dma_engine.sv
// Directed bench for jtag_dma_engine: buffer model, scripted bus slave and
// hand-computed expectations for write, read, stall, error, edge and reset cases.
module tb_jtag_dma_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        launch_rd, launch_wr;
  logic [31:0] dma_addr;
  logic [3:0]  dma_be;
  logic [7:0]  dma_bsz, dma_blk;
  logic        busy, done, err, sw_rdy;
  logic [8:0]  pp_addr;
  logic        pp_we;
  logic [31:0] pp_din, pp_dout;
  logic        b_req, b_gnt, b_begin, b_rnw, b_dv_out, b_end_out;
  logic [31:0] b_ad_out, b_ad_in;
  logic [3:0]  b_be;
  logic [7:0]  b_burst;
  logic        b_busy_in, b_dv_in, b_end_in, b_err_in;

  logic        tb_we;
  logic [8:0]  tb_wa;
  logic [31:0] tb_wd;
  logic [31:0] mem [512];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  jtag_dma_engine dut (
    .system_clk(clk), .system_reset(rst),
    .dma_launch_read(launch_rd), .dma_launch_write(launch_wr),
    .dma_address(dma_addr), .dma_byte_enable(dma_be),
    .dma_burst_size(dma_bsz), .dma_block_size(dma_blk),
    .dma_busy(busy), .dma_done(done), .dma_error(err), .switch_ready(sw_rdy),
    .pp_address(pp_addr), .pp_write_enable(pp_we), .pp_data_in(pp_din), .pp_data_out(pp_dout),
    .bus_request(b_req), .bus_grant(b_gnt), .bus_begin_transaction(b_begin),
    .bus_address_data_out(b_ad_out), .bus_byte_enables(b_be), .bus_burst_size(b_burst),
    .bus_read_n_write(b_rnw), .bus_data_valid_out(b_dv_out),
    .bus_end_transaction_out(b_end_out), .bus_busy_in(b_busy_in),
    .bus_data_valid_in(b_dv_in), .bus_address_data_in(b_ad_in),
    .bus_end_transaction_in(b_end_in), .bus_error_in(b_err_in)
  );

  // Synchronous-read ping-pong buffer model with a bench-side preload port
  always @(posedge clk) begin
    pp_dout <= mem[pp_addr];
    if (tb_we) mem[tb_wa] <= tb_wd;
    else if (pp_we) mem[pp_addr] <= pp_din;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input int a, input logic [31:0] d);
    tb_we = 1'b1; tb_wa = 9'(a); tb_wd = d;
    tick();
    tb_we = 1'b0;
  endtask

  task automatic launch(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [7:0] bsz, input logic [7:0] blk);
    launch_rd = rd; launch_wr = wr; dma_addr = a; dma_be = 4'hF;
    dma_bsz = bsz; dma_blk = blk;
    tick();
    launch_rd = 1'b0; launch_wr = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    for (int i = 0; i < 50 && !b_req; i++) tick();
    check_eq({tag, "_req"}, 32'(b_req), 1);
  endtask

  task automatic grant_begin(input string tag, input logic [31:0] a,
                             input logic [7:0] burst, input logic rnw);
    b_gnt = 1'b1;
    tick();
    b_gnt = 1'b0;
    check_eq({tag, "_begin"}, 32'(b_begin), 1);
    check_eq({tag, "_req_drop"}, 32'(b_req), 0);
    check_eq({tag, "_addr"}, b_ad_out, a);
    check_eq({tag, "_burst"}, 32'(b_burst), 32'(burst));
    check_eq({tag, "_rnw"}, 32'(b_rnw), 32'(rnw));
    check_eq({tag, "_be"}, 32'(b_be), 32'hF);
  endtask

  task automatic write_burst(input string tag, input logic [31:0] a, input int len,
                             input int pp0, input int stall_beat, input int stall_cyc);
    int k = 0;
    int s = 0;
    wait_req(tag);
    grant_begin(tag, a, 8'(len - 1), 1'b0);
    tick();
    for (int g = 0; g < 200 && !b_end_out; g++) begin
      check_eq({tag, "_dv"}, 32'(b_dv_out), 1);
      check_eq({tag, "_beat"}, b_ad_out, mem[9'(pp0 + k)]);
      if (k == stall_beat && s < stall_cyc) begin
        b_busy_in = 1'b1; s++;
      end else begin
        b_busy_in = 1'b0; k++;
      end
      tick();
    end
    b_busy_in = 1'b0;
    check_eq({tag, "_end"}, 32'(b_end_out), 1);
    check_eq({tag, "_nbeats"}, 32'(k), 32'(len));
    check_eq({tag, "_dv_off"}, 32'(b_dv_out), 0);
  endtask

  task automatic read_burst(input string tag, input logic [31:0] a, input int len,
                            input logic [31:0] dbase);
    wait_req(tag);
    grant_begin(tag, a, 8'(len - 1), 1'b1);
    tick();
    for (int i = 0; i < len; i++) begin
      b_dv_in = 1'b1; b_ad_in = dbase + 32'(i); b_end_in = (i == len - 1);
      tick();
    end
    b_dv_in = 1'b0; b_end_in = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 50 && !done; i++) tick();
    check_eq({tag, "_done"}, 32'(done), 1);
    check_eq({tag, "_busy_fall"}, 32'(busy), 0);
    tick();
    check_eq({tag, "_done_pulse"}, 32'(done), 0);
    check_eq({tag, "_switch_ready"}, 32'(sw_rdy), 1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_sw_rdy"}, 32'(sw_rdy), 1);
    check_eq({tag, "_busy"}, 32'(busy), 0);
    check_eq({tag, "_done"}, 32'(done), 0);
    check_eq({tag, "_err"}, 32'(err), 0);
    check_eq({tag, "_req"}, 32'(b_req), 0);
    check_eq({tag, "_dv"}, 32'(b_dv_out), 0);
    check_eq({tag, "_end"}, 32'(b_end_out), 0);
    check_eq({tag, "_ad"}, b_ad_out, 0);
    check_eq({tag, "_pp_we"}, 32'(pp_we), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int req_seen;
    rst = 1'b1; launch_rd = 1'b0; launch_wr = 1'b0; dma_addr = '0; dma_be = '0;
    dma_bsz = '0; dma_blk = '0; b_gnt = 1'b0; b_busy_in = 1'b0; b_dv_in = 1'b0;
    b_ad_in = '0; b_end_in = 1'b0; b_err_in = 1'b0; tb_we = 1'b0; tb_wa = '0; tb_wd = '0;
    tick(); tick();
    check_idle_outputs("reset");
    rst = 1'b0;
    tick();

    // 1: single write burst
    for (int i = 0; i < 4; i++) poke(i, 32'hA0A0_0000 + 32'(i));
    launch(1'b0, 1'b1, 32'h100, 8'd3, 8'd4);
    check_eq("w1_busy", 32'(busy), 1);
    check_eq("w1_sw_rdy", 32'(sw_rdy), 0);
    write_burst("w1", 32'h100, 4, 0, -1, 0);
    wait_done("w1");

    // 2: read split into 16 + 4
    launch(1'b1, 1'b0, 32'h0, 8'd15, 8'd20);
    read_burst("r2a", 32'h0, 16, 32'hD000_0000);
    read_burst("r2b", 32'h40, 4, 32'hD000_0010);
    wait_done("r2");
    for (int i = 0; i < 20; i++) check_eq("r2_mem", mem[i], 32'hD000_0000 + 32'(i));

    // 3: write with a 3-cycle stall on beat 1
    for (int i = 0; i < 4; i++) poke(i, 32'hB0B0_0000 + 32'(i));
    launch(1'b0, 1'b1, 32'h200, 8'd3, 8'd4);
    write_burst("w3", 32'h200, 4, 0, 1, 3);
    wait_done("w3");

    // 4: bus error on read beat 2 of 8
    launch(1'b1, 1'b0, 32'h300, 8'd7, 8'd8);
    wait_req("e4");
    grant_begin("e4", 32'h300, 8'd7, 1'b1);
    tick();
    for (int i = 0; i < 3; i++) begin
      b_dv_in = 1'b1; b_ad_in = 32'hE000_0000 + 32'(i); b_err_in = (i == 2);
      tick();
    end
    b_dv_in = 1'b0; b_err_in = 1'b0;
    check_eq("e4_err", 32'(err), 1);
    check_eq("e4_req_off", 32'(b_req), 0);
    check_eq("e4_busy_in_err", 32'(busy), 1);
    wait_done("e4");
    req_seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (b_req) req_seen++;
      tick();
    end
    check_eq("e4_no_req", 32'(req_seen), 0);
    check_eq("e4_err_sticky", 32'(err), 1);

    // 5: zero-length block, then simultaneous launch pulses
    launch(1'b0, 1'b1, 32'h800, 8'd3, 8'd0);
    check_eq("z5_done", 32'(done), 1);
    check_eq("z5_req", 32'(b_req), 0);
    check_eq("z5_busy", 32'(busy), 0);
    check_eq("z5_err_clr", 32'(err), 0);
    tick();
    check_eq("z5_sw_rdy", 32'(sw_rdy), 1);
    check_eq("z5_req2", 32'(b_req), 0);
    launch(1'b1, 1'b1, 32'h406, 8'd1, 8'd2);
    read_burst("rw5", 32'h404, 2, 32'hF000_0000);
    wait_done("rw5");
    check_eq("rw5_mem0", mem[0], 32'hF000_0000);
    check_eq("rw5_mem1", mem[1], 32'hF000_0001);

    // 6: reset while beat 2 of a write is on the bus, then a fresh write
    for (int i = 0; i < 4; i++) poke(i, 32'hC0C0_0000 + 32'(i));
    launch(1'b0, 1'b1, 32'h600, 8'd3, 8'd4);
    wait_req("x6");
    grant_begin("x6", 32'h600, 8'd3, 1'b0);
    tick(); tick(); tick();
    check_eq("x6_beat2", b_ad_out, 32'hC0C0_0002);
    rst = 1'b1;
    tick();
    check_idle_outputs("x6_rst");
    rst = 1'b0;
    tick();
    launch(1'b0, 1'b1, 32'h700, 8'd15, 8'd2);
    write_burst("x6n", 32'h700, 2, 0, -1, 0);
    wait_done("x6n");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
